// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: widths, opcode tags,
// output-stage state encoding and status-flag bit positions.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_OP_W  = 3;

    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_NEG    = 1;
    localparam int FLAG_PARITY = 2;
    localparam int FLAG_W      = 3;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the logic units (in_*) and write-back (out_*).
// The stage uses the slave modport; its environment uses master.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [OP_W-1:0]  in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OP_W-1:0]  out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity
    );

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/parity status for one result word.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0]  i_word,
    output logic [FLAG_W-1:0] o_flags
);
    assign o_flags[FLAG_ZERO]   = (i_word == '0);
    assign o_flags[FLAG_NEG]    = i_word[WIDTH-1];
    assign o_flags[FLAG_PARITY] = ^i_word;
endmodule

// File: rtl/alu_result_stage.sv
// Registered two-entry skid stage after the ALU logic units; flags are
// captured with each word. Optional counter: ALU_RESULT_STATS_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_stage_if.slave bus
`ifdef ALU_RESULT_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_count
`endif
);
    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_main_result;
    logic [OP_W-1:0]   r_main_op;
    logic [FLAG_W-1:0] r_main_flags;
    logic [WIDTH-1:0]  r_skid_result;
    logic [OP_W-1:0]   r_skid_op;
    logic [FLAG_W-1:0] r_skid_flags;
    logic [FLAG_W-1:0] w_in_flags;
    logic              w_in_acc;
    logic              w_out_acc;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .i_word  (bus.in_result),
        .o_flags (w_in_flags)
    );

    assign w_in_acc  = bus.in_valid & r_in_ready;
    assign w_out_acc = r_out_valid & bus.out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_acc) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_acc && w_out_acc) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_acc) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_out_acc) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_acc) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // NOTE: data registers are reset too, so out_* and the skid entry read as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_result <= '0;
            r_main_op     <= '0;
            r_main_flags  <= '0;
            r_skid_result <= '0;
            r_skid_op     <= '0;
            r_skid_flags  <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_result <= bus.in_result;
                r_main_op     <= bus.in_op;
                r_main_flags  <= w_in_flags;
            end else if (w_load_main_skid) begin
                r_main_result <= r_skid_result;
                r_main_op     <= r_skid_op;
                r_main_flags  <= r_skid_flags;
            end
            if (w_load_skid) begin
                r_skid_result <= bus.in_result;
                r_skid_op     <= bus.in_op;
                r_skid_flags  <= w_in_flags;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_main_result;
    assign bus.out_op     = r_main_op;
    assign bus.out_zero   = r_main_flags[FLAG_ZERO];
    assign bus.out_neg    = r_main_flags[FLAG_NEG];
    assign bus.out_parity = r_main_flags[FLAG_PARITY];

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] r_stat_count;

    // A clear coinciding with an output accept counts that accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_count <= '0;
        end else if (stat_clr) begin
            r_stat_count <= {15'd0, w_out_acc};
        end else if (w_out_acc) begin
            r_stat_count <= r_stat_count + 16'd1;
        end
    end

    assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; the counter section
// is exercised only when ALU_RESULT_STATS_EN is defined.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [15:0] q_exp_res[$];
    logic [2:0]  q_exp_op[$];

    alu_result_stage_if #(.WIDTH(16), .OP_W(3)) bus ();

`ifdef ALU_RESULT_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_count;
`endif

    alu_result_stage #(.WIDTH(16), .OP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef ALU_RESULT_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags as {parity, neg, zero}, built by counting bits.
    function automatic logic [2:0] model_flags(input logic [15:0] w);
        int ones = 0;
        for (int b = 0; b < 16; b++) ones += int'(w[b]);
        return {ones[0], w[15], (ones == 0)};
    endfunction

    function automatic logic [2:0] dut_flags();
        return {bus.out_parity, bus.out_neg, bus.out_zero};
    endfunction

    task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] op);
        bus.in_valid  = v;
        bus.in_result = res;
        bus.in_op     = op;
    endtask

    initial begin
        logic [15:0] w;
        logic [2:0]  o;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 3'd0);
        bus.out_ready = 1'b0;
`ifdef ALU_RESULT_STATS_EN
        stat_clr = 1'b0;
`endif
        #2 rst_n = 1'b0;
        tick();
        tick();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_op", bus.out_op, 0);
        check("rst_flags", dut_flags(), 0);
`ifdef ALU_RESULT_STATS_EN
        check("rst_stat_count", stat_count, 0);
`endif
        #3 rst_n = 1'b1;
        tick();

        // Single word, then an all-zero NOT result back to back.
        bus.out_ready = 1'b1;
        drive(1'b1, 16'hFB8A, OP_NOT);
        tick();
        check("w1_valid", bus.out_valid, 1);
        check("w1_result", bus.out_result, 16'hFB8A);
        check("w1_flags", dut_flags(), 3'b010);
        drive(1'b1, 16'h0000, OP_NOT);
        tick();
        check("w2_valid", bus.out_valid, 1);
        check("w2_result", bus.out_result, 16'h0000);
        check("w2_op", bus.out_op, OP_NOT);
        check("w2_flags", dut_flags(), 3'b001);
        drive(1'b0, 16'h0, 3'd0);
        tick();
        check("drain_valid", bus.out_valid, 0);

        // Stall: fill main and skid, in_ready must drop, output must hold.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h8B8A, OP_AND);
        tick();
        check("st1_in_ready", bus.in_ready, 1);
        check("st1_result", bus.out_result, 16'h8B8A);
        drive(1'b1, 16'h1234, OP_OR);
        tick();
        check("st2_in_ready", bus.in_ready, 0);
        check("st2_result", bus.out_result, 16'h8B8A);
        check("st2_flags", dut_flags(), 3'b110);
        drive(1'b1, 16'hFFFF, OP_ADD);
        tick();
        check("st3_in_ready", bus.in_ready, 0);
        check("st3_result", bus.out_result, 16'h8B8A);
        check("st3_op", bus.out_op, OP_AND);
        drive(1'b0, 16'h0, 3'd0);
        bus.out_ready = 1'b1;
        tick();
        check("st4_valid", bus.out_valid, 1);
        check("st4_result", bus.out_result, 16'h1234);
        check("st4_op", bus.out_op, OP_OR);
        check("st4_flags", dut_flags(), 3'b100);
        check("st4_in_ready", bus.in_ready, 1);
        tick();
        check("st5_valid", bus.out_valid, 0);

        // Full-rate stream against a scoreboard.
        w = 16'($urandom);
        o = 3'($urandom_range(0, 3));
        drive(1'b1, w, o);
        q_exp_res.push_back(w);
        q_exp_op.push_back(o);
        for (int i = 0; i < 100; i++) begin
            tick();
            w = q_exp_res.pop_front();
            o = q_exp_op.pop_front();
            check("strm_valid", bus.out_valid, 1);
            check("strm_in_ready", bus.in_ready, 1);
            check("strm_data", {bus.out_op, bus.out_result, dut_flags()},
                  {o, w, model_flags(w)});
            if (i < 99) begin
                w = 16'($urandom);
                o = 3'($urandom_range(0, 3));
                drive(1'b1, w, o);
                q_exp_res.push_back(w);
                q_exp_op.push_back(o);
            end else begin
                drive(1'b0, 16'h0, 3'd0);
            end
        end
        tick();
        check("strm_end_valid", bus.out_valid, 0);

        // Asynchronous reset while both entries are full.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, OP_AND);
        tick();
        drive(1'b1, 16'h5555, OP_OR);
        tick();
        drive(1'b0, 16'h0, 3'd0);
        check("ar_pre_in_ready", bus.in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_in_ready", bus.in_ready, 1);
        check("ar_out_result", bus.out_result, 0);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_stale", bus.out_valid, 0);
        end

`ifdef ALU_RESULT_STATS_EN
        check("sc_after_rst", stat_count, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(i + 1), OP_ADD);
            tick();
        end
        drive(1'b0, 16'h0, 3'd0);
        tick();
        check("sc_five", stat_count, 5);
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0042, OP_ADD);
        tick();
        drive(1'b0, 16'h0, 3'd0);
        bus.out_ready = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("sc_clr_accept", stat_count, 1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("sc_clr_idle", stat_count, 0);
        drive(1'b1, 16'h0001, OP_ADD);
        repeat (65536) tick();
        check("sc_ffff", stat_count, 16'hFFFF);
        tick();
        check("sc_wrap", stat_count, 16'h0000);
        drive(1'b0, 16'h0, 3'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit combinational logic units (NOT/AND/OR/ADD).
- Captures each unit result with a valid/ready handshake and derives zero/negative/parity status flags.
- Holds up to two results in a skid buffer so the consumer can stall without the ALU recomputing or losing data.
- Breaks the combinational path between the logic units and downstream register-file write-back.

Parameters:
- WIDTH, 16, data width of result path
- OP_W, 3, width of opcode tag carried alongside the result

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result this cycle
- in_result  input  WIDTH  result word from logic unit (e.g. NOT output)
- in_op  input  OP_W  opcode tag of the producing operation
- out_valid  output  1  registered result available
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  registered result
- out_op  output  OP_W  registered opcode tag
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[WIDTH-1]
- out_parity  output  1  XOR-reduction of out_result (1 = odd popcount)

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0, out_result=0, out_op=0, all flags 0, in_ready=1, skid entry cleared. Reset mid-transfer discards both entries; no partial output.
- Transfer rules: input accept = in_valid & in_ready; output accept = out_valid & out_ready.
- Storage: main register (drives out_*) plus one skid register. Flags are computed from the incoming word at capture and stored with it; they are never recomputed from out_result combinationally.
- State EMPTY (0 entries):
  - out_valid=0, in_ready=1.
  - Input accept -> load main; go to ONE.
- State ONE (main full):
  - out_valid=1, in_ready=1.
  - Input accept and output accept -> main reloads with new word; stay ONE.
  - Input accept only -> new word to skid; go to TWO.
  - Output accept only -> go to EMPTY.
- State TWO (main + skid full):
  - out_valid=1, in_ready=0.
  - Output accept -> skid moves to main; go to ONE.
  - in_valid is ignored.
- in_ready is a registered output: high in EMPTY and ONE, low in TWO. It has no combinational path from out_ready.
- Latency: 1 cycle from input accept to out_valid when empty. Sustained throughput is 1 word/cycle with out_ready held high.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- Holding rules:
  - out_* stay stable while out_valid=1 and out_ready=0.
  - in_result/in_op are don't-care when in_valid=0.
  - out_result value is don't-care (holds last value) when out_valid=0.
- WIDTH is generic; flags use the full WIDTH. No arithmetic width change.

Optional Feature:
- Macro: ALU_RESULT_STATS_EN.
- Defined:
  - Adds output stat_count (16 bits), counting output accepts.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0 by rst_n.
  - Adds input stat_clr (1 bit), a synchronous clear. If stat_clr and an accept occur in the same cycle, the result is count = 1.
- Undefined: stat_count and stat_clr ports and the counter logic are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH=16
  - opcode localparams: OP_NOT, OP_AND, OP_OR, OP_ADD
  - state encoding ST_EMPTY/ST_ONE/ST_TWO
  - flag bit indices
- Sub-module alu_flag_gen: combinational zero/neg/parity from a WIDTH word, instantiated once on the capture path.
- Skid control stays inline in the top module.

Test Plan:
- Reset, then in_valid=1, in_result=16'hFB8A (NOT of 16'h0475), out_ready=1 -> next cycle out_valid=1, out_result=FB8A, zero=0, neg=1, parity=0.
- Send in_result=16'h0000 (NOT of 16'hFFFF), op=OP_NOT -> out_zero=1, neg=0, parity=0, out_op=OP_NOT.
- Hold out_ready=0; send 8B8A then 1234 on consecutive cycles -> in_ready drops to 0 after the 2nd accept. Out holds 8B8A (neg=1, parity=1). Raise out_ready: 8B8A, then 1234, and in_ready returns to 1.
- Stream 100 random words with in_valid/out_ready both held 1 -> one output per cycle, order and flags match the scoreboard, no bubbles after the first.
- Fill to TWO, assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and in_ready=1 immediately. After release, no stale word is emitted.
- With ALU_RESULT_STATS_EN: 5 output accepts -> stat_count=5; stat_clr with simultaneous accept -> stat_count=1; preload wrap test at 0xFFFF -> 0x0000.
